// File: rtl/csr_pkg.sv
// Shared definitions for the CSR bank: register map addresses, access kinds,
// error flag bit positions and the default identification word.
package csr_pkg;

  localparam int CSR_ADDR_ID       = 0;
  localparam int CSR_ADDR_SCRATCH  = 1;
  localparam int CSR_ADDR_LED      = 2;
  localparam int CSR_ADDR_STATUS   = 3;
  localparam int CSR_ADDR_IRQ_EN   = 4;
  localparam int CSR_ADDR_WR_COUNT = 5;
  localparam int CSR_ADDR_ERR      = 6;
  localparam int CSR_ADDR_USER0    = 7;

  localparam int ERR_BIT_RO_WRITE = 0;
  localparam int ERR_BIT_UNMAPPED = 1;
  localparam int ERR_W            = 2;

  localparam int WR_COUNT_W = 16;

  localparam logic [31:0] CSR_DEFAULT_ID = 32'h4A54_4147;

  typedef enum logic [1:0] {
    ACC_RO,
    ACC_RW,
    ACC_W1C
  } csr_acc_e;

  // Access kind of a mapped slot; callers must reject addresses >= NUM_REGS first.
  function automatic csr_acc_e csr_access(input int addr);
    csr_acc_e acc;
    case (addr)
      CSR_ADDR_ID, CSR_ADDR_WR_COUNT: acc = ACC_RO;
      CSR_ADDR_STATUS, CSR_ADDR_ERR:  acc = ACC_W1C;
      default:                        acc = ACC_RW;
    endcase
    csr_access = acc;
  endfunction

endpackage

// File: rtl/cdc_toggle_sync.sv
// Brings a toggle-encoded request from another clock domain into clk and
// turns every edge of the toggle into a single-cycle pulse.
module cdc_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tgl_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // History flop holds the previous synchronised level, so any change is one pulse.
  assign pulse = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/csr_bank.sv
// System-clock CSR bank fed by toggle-encoded JTAG address/data updates;
// decodes the register map, holds the register file and drives read-back.
module csr_bank
  import csr_pkg::*;
#(
  parameter int                NUM_REGS    = 8,
  parameter int                ADDR_W      = $clog2(NUM_REGS),
  parameter int                DATA_W      = 32,
  parameter int                LED_W       = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(CSR_DEFAULT_ID)
) (
  input  logic                                     sys_clk,
  input  logic                                     sys_rst_n,
  input  logic                                     dr_csr_addr_tgl,
  input  logic [ADDR_W-1:0]                        dr_csr_addr,
  input  logic                                     dr_csr_data_tgl,
  input  logic [DATA_W-1:0]                        dr_csr_data,
  input  logic [DATA_W-1:0]                        hw_status_set,
  output logic [ADDR_W-1:0]                        csr_addr,
  output logic [DATA_W-1:0]                        csr_data,
  output logic [LED_W-1:0]                         led,
  output logic [(NUM_REGS-CSR_ADDR_USER0)*DATA_W-1:0] user_regs,
  output logic                                     irq
);

  localparam int NUM_USER = NUM_REGS - CSR_ADDR_USER0;

  if (NUM_REGS < 8) begin : g_bad_num_regs
    $error("csr_bank: NUM_REGS must be at least 8");
  end
  if (LED_W > DATA_W || DATA_W < WR_COUNT_W) begin : g_bad_widths
    $error("csr_bank: LED_W must fit in DATA_W and DATA_W must hold WR_COUNT");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("csr_bank: SYNC_STAGES must be at least 2");
  end

  logic addr_pulse;
  logic data_pulse;

  cdc_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_addr_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .tgl_in(dr_csr_addr_tgl),
    .pulse (addr_pulse)
  );

  cdc_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_data_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .tgl_in(dr_csr_data_tgl),
    .pulse (data_pulse)
  );

  logic [ADDR_W-1:0]                csr_addr_q, csr_addr_d;
  logic [DATA_W-1:0]                csr_data_q, csr_data_d;
  logic [DATA_W-1:0]                scratch_q, scratch_d;
  logic [LED_W-1:0]                 led_q, led_d;
  logic [DATA_W-1:0]                status_q, status_d;
  logic [DATA_W-1:0]                irq_en_q, irq_en_d;
  logic [WR_COUNT_W-1:0]            wr_count_q, wr_count_d;
  logic [ERR_W-1:0]                 err_q, err_d;
  logic [NUM_USER-1:0][DATA_W-1:0]  user_q, user_d;
  logic                             irq_q, irq_d;

  logic [ADDR_W-1:0] wr_addr;
  int                wr_idx;
  int                rd_idx;
  logic [DATA_W-1:0] status_clr;
  logic [ERR_W-1:0]  err_clr;
  logic [ERR_W-1:0]  err_set;

  // A write landing with a same-cycle address update targets the new address.
  always_comb begin
    csr_addr_d = csr_addr_q;
    scratch_d  = scratch_q;
    led_d      = led_q;
    irq_en_d   = irq_en_q;
    wr_count_d = wr_count_q;
    user_d     = user_q;
    status_clr = '0;
    err_clr    = '0;
    err_set    = '0;
    wr_addr    = addr_pulse ? dr_csr_addr : csr_addr_q;
    wr_idx     = int'(wr_addr);

    if (addr_pulse) begin
      csr_addr_d = dr_csr_addr;
      if (int'(dr_csr_addr) >= NUM_REGS) begin
        err_set[ERR_BIT_UNMAPPED] = 1'b1;
      end
    end

    if (data_pulse) begin
      wr_count_d = wr_count_q + WR_COUNT_W'(1);
      if (wr_idx >= NUM_REGS) begin
        err_set[ERR_BIT_UNMAPPED] = 1'b1;
      end else begin
        case (csr_access(wr_idx))
          ACC_RO: err_set[ERR_BIT_RO_WRITE] = 1'b1;
          ACC_W1C: begin
            if (wr_idx == CSR_ADDR_STATUS) begin
              status_clr = dr_csr_data;
            end else begin
              err_clr = dr_csr_data[ERR_W-1:0];
            end
          end
          default: begin
            if (wr_idx == CSR_ADDR_SCRATCH) scratch_d = dr_csr_data;
            if (wr_idx == CSR_ADDR_LED)     led_d     = dr_csr_data[LED_W-1:0];
            if (wr_idx == CSR_ADDR_IRQ_EN)  irq_en_d  = dr_csr_data;
            for (int i = 0; i < NUM_USER; i++) begin
              if (wr_idx == CSR_ADDR_USER0 + i) user_d[i] = dr_csr_data;
            end
          end
        endcase
      end
    end

    // Hardware sets are applied after software clears so a coincident set survives.
    status_d = (status_q & ~status_clr) | hw_status_set;
    err_d    = (err_q & ~err_clr) | err_set;
    irq_d    = |(status_q & irq_en_q);
  end

  always_comb begin
    rd_idx     = int'(csr_addr_q);
    csr_data_d = '0;
    case (rd_idx)
      CSR_ADDR_ID:       csr_data_d = ID_VALUE;
      CSR_ADDR_SCRATCH:  csr_data_d = scratch_q;
      CSR_ADDR_LED:      csr_data_d = DATA_W'(led_q);
      CSR_ADDR_STATUS:   csr_data_d = status_q;
      CSR_ADDR_IRQ_EN:   csr_data_d = irq_en_q;
      CSR_ADDR_WR_COUNT: csr_data_d = DATA_W'(wr_count_q);
      CSR_ADDR_ERR:      csr_data_d = DATA_W'(err_q);
      default: begin
        for (int i = 0; i < NUM_USER; i++) begin
          if (rd_idx == CSR_ADDR_USER0 + i) csr_data_d = user_q[i];
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csr_addr_q <= '0;
      csr_data_q <= '0;
      scratch_q  <= '0;
      led_q      <= '0;
      status_q   <= '0;
      irq_en_q   <= '0;
      wr_count_q <= '0;
      err_q      <= '0;
      user_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      csr_addr_q <= csr_addr_d;
      csr_data_q <= csr_data_d;
      scratch_q  <= scratch_d;
      led_q      <= led_d;
      status_q   <= status_d;
      irq_en_q   <= irq_en_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
      user_q     <= user_d;
      irq_q      <= irq_d;
    end
  end

  assign csr_addr  = csr_addr_q;
  assign csr_data  = csr_data_q;
  assign led       = led_q;
  assign user_regs = user_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_csr_bank.sv
// Randomised bench for csr_bank with ten register slots, checked against a
// register-map model that applies the access rules one transaction at a time.
module tb_csr_bank;

  localparam int          NUM_REGS    = 10;
  localparam int          ADDR_W      = 4;
  localparam int          DATA_W      = 32;
  localparam int          LED_W       = 4;
  localparam int          SYNC_STAGES = 2;
  localparam int          NUM_USER    = NUM_REGS - 7;
  localparam logic [31:0] ID_VALUE    = 32'h4A54_4147;

  logic                         sys_clk;
  logic                         sys_rst_n;
  logic                         dr_csr_addr_tgl;
  logic [ADDR_W-1:0]            dr_csr_addr;
  logic                         dr_csr_data_tgl;
  logic [DATA_W-1:0]            dr_csr_data;
  logic [DATA_W-1:0]            hw_status_set;
  logic [ADDR_W-1:0]            csr_addr;
  logic [DATA_W-1:0]            csr_data;
  logic [LED_W-1:0]             led;
  logic [NUM_USER*DATA_W-1:0]   user_regs;
  logic                         irq;

  int tests_run;
  int tests_failed;

  // Reference state indexed by register address; slot 0 is unused (ID is constant).
  logic [31:0] m_regs [NUM_REGS];
  int          m_addr;

  csr_bank #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LED_W      (LED_W),
    .SYNC_STAGES(SYNC_STAGES),
    .ID_VALUE   (ID_VALUE)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .dr_csr_addr_tgl(dr_csr_addr_tgl),
    .dr_csr_addr    (dr_csr_addr),
    .dr_csr_data_tgl(dr_csr_data_tgl),
    .dr_csr_data    (dr_csr_data),
    .hw_status_set  (hw_status_set),
    .csr_addr       (csr_addr),
    .csr_data       (csr_data),
    .led            (led),
    .user_regs      (user_regs),
    .irq            (irq)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_addr = 0;
  endtask

  function automatic logic [31:0] modelRead(input int a);
    if (a >= NUM_REGS) return 32'h0;
    if (a == 0) return ID_VALUE;
    return m_regs[a];
  endfunction

  task automatic modelSelect(input int a);
    m_addr = a;
    if (a >= NUM_REGS) m_regs[6] = m_regs[6] | 32'h2;
  endtask

  task automatic modelWrite(input int a, input logic [31:0] d);
    m_regs[5] = (m_regs[5] + 32'h1) & 32'h0000_FFFF;
    if (a >= NUM_REGS)          m_regs[6] = m_regs[6] | 32'h2;
    else if (a == 0 || a == 5)  m_regs[6] = m_regs[6] | 32'h1;
    else if (a == 3)            m_regs[3] = m_regs[3] & ~d;
    else if (a == 6)            m_regs[6] = m_regs[6] & ~(d & 32'h3);
    else if (a == 2)            m_regs[2] = d & 32'hF;
    else                        m_regs[a] = d;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [NUM_USER*DATA_W-1:0] exp_user;
    for (int i = 0; i < NUM_USER; i++) exp_user[i*DATA_W +: DATA_W] = m_regs[7+i];
    checkOutput({tag, "/csr_addr"}, 128'(csr_addr), 128'(m_addr));
    checkOutput({tag, "/csr_data"}, 128'(csr_data), 128'(modelRead(m_addr)));
    checkOutput({tag, "/led"}, 128'(led), 128'(m_regs[2][3:0]));
    checkOutput({tag, "/user_regs"}, 128'(user_regs), 128'(exp_user));
    checkOutput({tag, "/irq"}, 128'(irq), 128'(|(m_regs[3] & m_regs[4])));
  endtask

  // kind 0: address update, 1: data write, 2: both in the same cycle, 3: status set pulse
  task automatic applyStimulus(input int kind, input int a, input logic [31:0] d, input logic [31:0] s);
    case (kind)
      0: begin
        dr_csr_addr = ADDR_W'(a);
        dr_csr_addr_tgl = ~dr_csr_addr_tgl;
        step(SYNC_STAGES + 2);
        modelSelect(a);
      end
      1: begin
        dr_csr_data = d;
        dr_csr_data_tgl = ~dr_csr_data_tgl;
        step(SYNC_STAGES + 2);
        modelWrite(m_addr, d);
      end
      2: begin
        dr_csr_addr = ADDR_W'(a);
        dr_csr_data = d;
        dr_csr_addr_tgl = ~dr_csr_addr_tgl;
        dr_csr_data_tgl = ~dr_csr_data_tgl;
        step(SYNC_STAGES + 2);
        modelSelect(a);
        modelWrite(a, d);
      end
      default: begin
        hw_status_set = s;
        step(1);
        hw_status_set = '0;
        step(1);
        m_regs[3] = m_regs[3] | s;
      end
    endcase
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    sys_rst_n       = 1'b0;
    dr_csr_addr_tgl = 1'b0;
    dr_csr_data_tgl = 1'b0;
    dr_csr_addr     = '0;
    dr_csr_data     = '0;
    hw_status_set   = '0;
    modelReset();

    step(2);
    checkOutput("rst_csr_data", 128'(csr_data), 128'(0));
    checkOutput("rst_led", 128'(led), 128'(0));
    checkOutput("rst_irq", 128'(irq), 128'(0));
    checkOutput("rst_user", 128'(user_regs), 128'(0));
    sys_rst_n = 1'b1;
    step(1);
    checkOutput("id_after_reset", 128'(csr_data), 128'(ID_VALUE));
    checkAll("idle");

    // LED write with exact response latency
    applyStimulus(0, 2, '0, '0);
    dr_csr_data = 32'h0000_000A;
    dr_csr_data_tgl = ~dr_csr_data_tgl;
    step(SYNC_STAGES + 1);
    checkOutput("led_latency", 128'(led), 128'(4'hA));
    checkOutput("read_not_early", 128'(csr_data), 128'(0));
    step(1);
    checkOutput("read_latency", 128'(csr_data), 128'(32'hA));
    modelWrite(2, 32'h0000_000A);
    checkAll("led_write");
    applyStimulus(0, 5, '0, '0);
    checkOutput("wr_count_1", 128'(csr_data), 128'(1));

    // Same-cycle address and data: write must go to the new address
    applyStimulus(0, 4, '0, '0);
    applyStimulus(2, 1, 32'hDEAD_BEEF, '0);
    checkOutput("scratch_same_cycle", 128'(csr_data), 128'(32'hDEAD_BEEF));
    applyStimulus(0, 4, '0, '0);
    checkAll("prior_addr_untouched");

    // Read-only write and W1C error clear
    applyStimulus(0, 0, '0, '0);
    applyStimulus(1, 0, 32'h1234, '0);
    checkAll("ro_write");
    applyStimulus(0, 6, '0, '0);
    checkOutput("err_ro", 128'(csr_data), 128'(1));
    applyStimulus(1, 0, 32'h1, '0);
    checkOutput("err_cleared", 128'(csr_data), 128'(0));
    applyStimulus(0, 5, '0, '0);
    checkAll("wr_count_after_errs");

    // Status, interrupt enable and irq timing
    applyStimulus(0, 4, '0, '0);
    applyStimulus(1, 0, 32'h4, '0);
    applyStimulus(0, 3, '0, '0);
    hw_status_set = 32'h4;
    step(1);
    hw_status_set = '0;
    checkOutput("irq_not_early", 128'(irq), 128'(0));
    step(1);
    m_regs[3] = m_regs[3] | 32'h4;
    checkOutput("irq_set", 128'(irq), 128'(1));
    checkOutput("status_set", 128'(csr_data), 128'(32'h4));

    dr_csr_data = 32'h4;
    dr_csr_data_tgl = ~dr_csr_data_tgl;
    step(SYNC_STAGES);
    hw_status_set = 32'h4;
    step(1);
    hw_status_set = '0;
    step(1);
    modelWrite(3, 32'h4);
    m_regs[3] = m_regs[3] | 32'h4;
    checkAll("set_beats_clear");
    applyStimulus(1, 0, 32'h4, '0);
    checkAll("w1c_alone");
    checkOutput("irq_cleared", 128'(irq), 128'(0));

    // User register and unmapped access
    applyStimulus(0, 9, '0, '0);
    applyStimulus(1, 0, 32'h55, '0);
    checkOutput("user9", 128'(user_regs[95:64]), 128'(32'h55));
    checkAll("user_write");
    applyStimulus(0, 12, '0, '0);
    checkOutput("unmapped_read", 128'(csr_data), 128'(0));
    checkAll("unmapped_sel");
    applyStimulus(0, 6, '0, '0);
    checkOutput("err_unmapped", 128'(csr_data[1]), 128'(1));

    // Randomised transactions
    for (int n = 0; n < 80; n++) begin
      int          kind;
      int          a;
      logic [31:0] d;
      logic [31:0] s;
      kind = int'($urandom_range(0, 3));
      a    = int'($urandom_range(0, 15));
      d    = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'hF);
      s    = $urandom & 32'h0000_00FF;
      applyStimulus(kind, a, d, s);
      checkAll("random");
    end

    // Reset in the middle of a pending write
    applyStimulus(0, 1, '0, '0);
    dr_csr_data = 32'h77;
    dr_csr_data_tgl = ~dr_csr_data_tgl;
    step(1);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("midrst_csr_data", 128'(csr_data), 128'(0));
    checkOutput("midrst_csr_addr", 128'(csr_addr), 128'(0));
    checkOutput("midrst_led", 128'(led), 128'(0));
    checkOutput("midrst_user", 128'(user_regs), 128'(0));
    checkOutput("midrst_irq", 128'(irq), 128'(0));
    dr_csr_addr_tgl = 1'b0;
    dr_csr_data_tgl = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
    modelReset();
    step(SYNC_STAGES + 3);
    checkAll("after_midrst");
    applyStimulus(0, 1, '0, '0);
    checkOutput("no_partial_write", 128'(csr_data), 128'(0));
    applyStimulus(0, 5, '0, '0);
    checkAll("count_after_midrst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
